bill_accum: RTL and testbench

BILL_ACCUM -- requirements
Module: bill_accum

---
 rtl/bill_accum_pkg.sv | 15 +
 rtl/bill_accum_if.sv | 26 ++
 rtl/bill_accum_add_13bit.sv | 23 ++
 rtl/bill_accum.sv | 113 +++++++++++
 tb/tb_bill_accum.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/bill_accum_pkg.sv
// Shared constants and FSM state type for the bill accumulator.
// Amount width defaults to 13 bits (rupees up to 8191).
package bill_accum_pkg;

    localparam int WIDTH_DEF = 13;
    localparam int CNT_W_DEF = 8;
    localparam logic [WIDTH_DEF-1:0] AMT_MAX = 13'd8191;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } bill_state_e;

endpackage

// File: rtl/bill_accum_if.sv
// Item/bill handshake bundle between a bill source (master) and the accumulator (slave).
interface bill_accum_if #(
    parameter int WIDTH = 13,
    parameter int CNT_W = 8
);
    logic             start;
    logic             item_valid;
    logic [WIDTH-1:0] item_amt;
    logic             item_ready;
    logic             finish;
    logic [WIDTH-1:0] total;
    logic             total_valid;
    logic             overflow;
    logic [CNT_W-1:0] item_count;
    logic             busy;

    modport master (
        output start, item_valid, item_amt, finish,
        input  item_ready, total, total_valid, overflow, item_count, busy
    );

    modport slave (
        input  start, item_valid, item_amt, finish,
        output item_ready, total, total_valid, overflow, item_count, busy
    );
endinterface

// File: rtl/bill_accum_add_13bit.sv
// Gate-level ripple-carry adder built from full-adder cells, carry-in tied low.
// Same cell structure as the existing 13-bit subtractor.
module add_13bit
    import bill_accum_pkg::*;
#(
    parameter int W = WIDTH_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign cout = carry_s[W];
endmodule

// File: rtl/bill_accum.sv
// Bill accumulator: sums item amounts between start and finish with saturation
// at full scale, a sticky overflow flag and a saturating item counter.
module bill_accum
    import bill_accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    bill_accum_if.slave  bus
);
    bill_state_e      state_r;
    bill_state_e      state_nxt_s;
    logic [WIDTH-1:0] total_r;
    logic [WIDTH-1:0] total_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic             ready_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sum_s;
    logic             carry_s;

    assign ready_s = (state_r == ST_ACCUM) && !bus.start;
    assign xfer_s  = bus.item_valid && ready_s;

    add_13bit #(.W(WIDTH)) u_add (
        .a    (total_r),
        .b    (bus.item_amt),
        .sum  (sum_s),
        .cout (carry_s)
    );

    // Next-state logic; start always (re)opens a bill and beats finish
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nxt_s = ST_ACCUM;
                else           state_nxt_s = ST_IDLE;
            end
            ST_ACCUM: begin
                if (bus.start)       state_nxt_s = ST_ACCUM;
                else if (bus.finish) state_nxt_s = ST_DONE;
                else                 state_nxt_s = ST_ACCUM;
            end
            ST_DONE: begin
                if (bus.start) state_nxt_s = ST_ACCUM;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath next values; overflow pins the total at full scale for the rest of the bill
    always_comb begin
        total_nxt_s = total_r;
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        if (bus.start) begin
            total_nxt_s = {WIDTH{1'b0}};
            count_nxt_s = {CNT_W{1'b0}};
            ovf_nxt_s   = 1'b0;
        end else if (xfer_s) begin
            if (ovf_r || carry_s) begin
                total_nxt_s = {WIDTH{1'b1}};
                ovf_nxt_s   = 1'b1;
            end else begin
                total_nxt_s = sum_s;
                ovf_nxt_s   = 1'b0;
            end
            if (&count_r) begin
                count_nxt_s = count_r;
            end else begin
                count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            total_nxt_s = total_r;
            count_nxt_s = count_r;
            ovf_nxt_s   = ovf_r;
        end
    end

    // State, datapath and status flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            total_r <= {WIDTH{1'b0}};
            count_r <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            total_r <= total_nxt_s;
            count_r <= count_nxt_s;
            ovf_r   <= ovf_nxt_s;
            busy_r  <= (state_nxt_s == ST_ACCUM);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.item_ready  = ready_s;
    assign bus.total       = total_r;
    assign bus.item_count  = count_r;
    assign bus.overflow    = ovf_r;
    assign bus.busy        = busy_r;
    assign bus.total_valid = done_r;
endmodule

// File: tb/tb_bill_accum.sv
// Self-checking bench for bill_accum: directed vector table, hand-written reset
// and saturation sequences, then random traffic against an integer reference model.
module tb_bill_accum;
    localparam int WIDTH = 13;
    localparam int CNT_W = 8;
    localparam int TMAX  = 8191;
    localparam int CMAX  = 255;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    bill_accum_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bif ();

    bill_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic st;
        logic vl;
        int   amt;
        logic fin;
        logic exp_rdy;
        int   exp_tot;
        int   exp_cnt;
        logic exp_ovf;
        logic exp_tv;
        logic exp_busy;
    } vec_t;

    vec_t tbl[18];

    // reference model state: 0 idle, 1 bill open, 2 bill closed
    int m_state;
    int m_tot;
    int m_cnt;
    int m_ovf;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic vl, input int amt, input logic fin);
        @(negedge clk);
        bif.start      = st;
        bif.item_valid = vl;
        bif.item_amt   = WIDTH'(amt);
        bif.finish     = fin;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bif.start = 1'b0; bif.item_valid = 1'b0; bif.item_amt = '0; bif.finish = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_state = 0; m_tot = 0; m_cnt = 0; m_ovf = 0;
    endtask

    // Bill rules in plain integer arithmetic
    task automatic model_step(input logic st, input logic vl, input int amt, input logic fin);
        if (st) begin
            m_state = 1; m_tot = 0; m_cnt = 0; m_ovf = 0;
        end else if (m_state == 1) begin
            if (vl) begin
                m_tot = m_tot + amt;
                if (m_tot > TMAX) begin
                    m_tot = TMAX;
                    m_ovf = 1;
                end
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end
            if (fin) m_state = 2;
        end
    endtask

    task automatic chk_outputs(input string tag, input int tot, input int cnt,
                               input int ovf, input int tv, input int bsy);
        chk({tag, ".total"},       int'(bif.total),       tot);
        chk({tag, ".item_count"},  int'(bif.item_count),  cnt);
        chk({tag, ".overflow"},    int'(bif.overflow),    ovf);
        chk({tag, ".total_valid"}, int'(bif.total_valid), tv);
        chk({tag, ".busy"},        int'(bif.busy),        bsy);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        bif.start = 1'b0; bif.item_valid = 1'b0; bif.item_amt = '0; bif.finish = 1'b0;

        //              st   vl   amt   fin   rdy  tot   cnt ovf  tv   busy
        tbl[0]  = '{1'b1, 1'b0,    0, 1'b0, 1'b0,    0, 0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1,  100, 1'b0, 1'b1,  100, 1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1,  250, 1'b0, 1'b1,  350, 2, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1,   37, 1'b0, 1'b1,  387, 3, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0,    0, 1'b1, 1'b1,  387, 3, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1,   55, 1'b0, 1'b0,  387, 3, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0,    0, 1'b0, 1'b0,    0, 0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 8000, 1'b0, 1'b1, 8000, 1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1,  500, 1'b0, 1'b1, 8191, 2, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1,    1, 1'b0, 1'b1, 8191, 3, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0,    0, 1'b0, 1'b0,    0, 0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1,   60, 1'b0, 1'b1,   60, 1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1,   40, 1'b1, 1'b1,  100, 2, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0,    0, 1'b0, 1'b0,    0, 0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1,  500, 1'b0, 1'b1,  500, 1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1,    9, 1'b0, 1'b0,    0, 0, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b1,  200, 1'b0, 1'b1,  200, 1, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b1,  500, 1'b0, 1'b1,  700, 2, 1'b0, 1'b0, 1'b1};

        do_reset();
        #1;
        chk("reset.item_ready", int'(bif.item_ready), 0);
        chk_outputs("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].st, tbl[i].vl, tbl[i].amt, tbl[i].fin);
            chk($sformatf("tbl%0d.item_ready", i), int'(bif.item_ready), int'(tbl[i].exp_rdy));
            tick();
            chk_outputs($sformatf("tbl%0d", i), tbl[i].exp_tot, tbl[i].exp_cnt,
                        int'(tbl[i].exp_ovf), int'(tbl[i].exp_tv), int'(tbl[i].exp_busy));
        end

        // Asynchronous reset in the middle of a cycle with a bill of 700 open
        drive(1'b0, 1'b1, 5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.total", int'(bif.total), 0);
        chk("async_rst.busy", int'(bif.busy), 0);
        chk("async_rst.item_ready", int'(bif.item_ready), 0);
        tick();
        chk_outputs("rst_held", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bif.item_valid = 1'b1;
        bif.item_amt = 13'd55;
        #1;
        chk("idle_item.item_ready", int'(bif.item_ready), 0);
        tick();
        chk_outputs("idle_item", 0, 0, 0, 0, 0);
        drive(1'b1, 1'b0, 0, 1'b0);
        tick();
        chk_outputs("first_start", 0, 0, 0, 0, 1);

        // Item counter saturates rather than wrapping
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, 1'b1, 0, 1'b0);
            tick();
        end
        chk_outputs("cnt_sat", 0, CMAX, 0, 0, 1);

        // Random traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic st, vl, fin;
            int   amt;
            st  = ($urandom_range(0, 15) == 0);
            fin = ($urandom_range(0, 11) == 0);
            vl  = ($urandom_range(0, 1) == 1);
            amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMAX))
                                              : int'($urandom_range(0, 300));
            drive(st, vl, amt, fin);
            chk("rnd.item_ready", int'(bif.item_ready), int'(m_state == 1 && !st));
            tick();
            model_step(st, vl, amt, fin);
            chk_outputs("rnd", m_tot, m_cnt, m_ovf, int'(m_state == 2), int'(m_state == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
